demo_scene_sequencer: RTL and testbench

Frame-rate animation controller for the black hole VGA demo. It watches the timing generator's vsync and advances the scene once per frame: ring texture phase, the falling "UW" text position, the text's swallow/respawn cycle and its fade level. It replaces the free-running frame counter and ad-hoc bit-sliced text animation in the top level. The pixel renderer consumes its registered outputs unchanged for a whole frame.

---
 rtl/demo_scene_pkg.sv | 20 ++
 rtl/demo_scene_if.sv | 23 ++
 rtl/demo_scene_frame_tick_detect.sv | 17 +
 rtl/demo_scene_sequencer.sv | 152 +++++++++++++++
 tb/tb_demo_scene_sequencer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/demo_scene_pkg.sv
// Shared types and constants for the black hole demo scene sequencer.
package demo_scene_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        FALL    = 2'd1,
        DARK    = 2'd2,
        FADE_IN = 2'd3
    } scene_state_t;

    // Text fall velocity limit and the number of FALL frames per velocity step.
    localparam int VEL_MAX    = 8;
    localparam int VEL_PERIOD = 16;

    // Ring phase advance per frame: 1, 2, 4 or 8.
    function automatic logic [7:0] speed_step(input logic [1:0] speed);
        return 8'd1 << speed;
    endfunction

endpackage

// File: rtl/demo_scene_if.sv
// Control inputs and per-frame animation outputs of the scene sequencer.
interface demo_scene_if;
    logic        vsync;
    logic        pause;
    logic [1:0]  speed;
    logic        frame_tick;
    logic [15:0] frame_cnt;
    logic [7:0]  ring_phase;
    logic [9:0]  text_y;
    logic        text_on;
    logic [1:0]  text_fade;
    logic [1:0]  scene_state;

    modport master (
        output vsync, pause, speed,
        input  frame_tick, frame_cnt, ring_phase, text_y, text_on, text_fade, scene_state
    );

    modport slave (
        input  vsync, pause, speed,
        output frame_tick, frame_cnt, ring_phase, text_y, text_on, text_fade, scene_state
    );
endinterface

// File: rtl/demo_scene_frame_tick_detect.sv
// Detects the end of the active-low vsync pulse, once per frame.
module frame_tick_detect (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic tick
);
    logic vsync_prev;

    // Previous vsync level; resets high so a vsync already high at release is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) vsync_prev <= 1'b1;
        else       vsync_prev <= vsync;
    end

    assign tick = vsync & ~vsync_prev;
endmodule

// File: rtl/demo_scene_sequencer.sv
// Frame-rate animation controller: ring phase, falling text, swallow/respawn and fade.
module demo_scene_sequencer
    import demo_scene_pkg::*;
#(
    parameter int HOLD_FRAMES      = 256,
    parameter int TEXT_Y_TOP       = 20,
    parameter int TEXT_Y_END       = 276,
    parameter int DARK_FRAMES      = 32,
    parameter int FADE_STEP_FRAMES = 8
) (
    input logic          clk,
    input logic          reset,
    demo_scene_if.slave  bus
);
    localparam int HOLD_W = (HOLD_FRAMES > 1)      ? $clog2(HOLD_FRAMES)      : 1;
    localparam int DARK_W = (DARK_FRAMES > 1)      ? $clog2(DARK_FRAMES)      : 1;
    localparam int FADE_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;

    logic tick;

    frame_tick_detect u_tick (
        .clk   (clk),
        .reset (reset),
        .vsync (bus.vsync),
        .tick  (tick)
    );

    scene_state_t      state,      state_nx;
    logic [HOLD_W-1:0] hold_cnt,   hold_cnt_nx;
    logic [DARK_W-1:0] dark_cnt,   dark_cnt_nx;
    logic [FADE_W-1:0] fade_cnt,   fade_cnt_nx;
    logic [3:0]        fall_cnt,   fall_cnt_nx;
    logic [3:0]        vel,        vel_nx;
    logic [9:0]        text_y,     text_y_nx;
    logic              text_on,    text_on_nx;
    logic [1:0]        text_fade,  text_fade_nx;
    logic [7:0]        ring_phase, ring_phase_nx;
    logic [15:0]       frame_cnt,  frame_cnt_nx;
    logic              frame_tick;
    logic [10:0]       next_y;

    // All scene state is registered; updates only land on the edge ending a tick cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            dark_cnt   <= '0;
            fade_cnt   <= '0;
            fall_cnt   <= '0;
            vel        <= 4'd1;
            text_y     <= 10'(TEXT_Y_TOP);
            text_on    <= 1'b1;
            text_fade  <= 2'd3;
            ring_phase <= '0;
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nx;
            hold_cnt   <= hold_cnt_nx;
            dark_cnt   <= dark_cnt_nx;
            fade_cnt   <= fade_cnt_nx;
            fall_cnt   <= fall_cnt_nx;
            vel        <= vel_nx;
            text_y     <= text_y_nx;
            text_on    <= text_on_nx;
            text_fade  <= text_fade_nx;
            ring_phase <= ring_phase_nx;
            frame_cnt  <= frame_cnt_nx;
            frame_tick <= tick;
        end
    end

    // Next-state: frame counter runs on every tick, the scene only on unpaused ticks.
    always_comb begin
        state_nx      = state;
        hold_cnt_nx   = hold_cnt;
        dark_cnt_nx   = dark_cnt;
        fade_cnt_nx   = fade_cnt;
        fall_cnt_nx   = fall_cnt;
        vel_nx        = vel;
        text_y_nx     = text_y;
        text_on_nx    = text_on;
        text_fade_nx  = text_fade;
        ring_phase_nx = ring_phase;
        frame_cnt_nx  = frame_cnt;
        // 11-bit sum so a position near the bottom cannot wrap past the swallow row.
        next_y        = {1'b0, text_y} + {7'd0, vel};

        if (tick) begin
            frame_cnt_nx = frame_cnt + 16'd1;
            if (!bus.pause) begin
                ring_phase_nx = ring_phase + speed_step(bus.speed);
                case (state)
                    HOLD: begin
                        if (hold_cnt == HOLD_W'(HOLD_FRAMES - 1)) begin
                            state_nx    = FALL;
                            hold_cnt_nx = '0;
                            vel_nx      = 4'd1;
                        end else begin
                            hold_cnt_nx = hold_cnt + HOLD_W'(1);
                        end
                    end
                    FALL: begin
                        if (next_y >= 11'(TEXT_Y_END)) begin
                            text_y_nx   = 10'(TEXT_Y_END);
                            text_on_nx  = 1'b0;
                            dark_cnt_nx = '0;
                            state_nx    = DARK;
                        end else begin
                            text_y_nx   = next_y[9:0];
                        end
                        fall_cnt_nx = fall_cnt + 4'd1;
                        if (fall_cnt == 4'(VEL_PERIOD - 1) && vel < 4'(VEL_MAX))
                            vel_nx = vel + 4'd1;
                    end
                    DARK: begin
                        if (dark_cnt == DARK_W'(DARK_FRAMES - 1)) begin
                            text_y_nx    = 10'(TEXT_Y_TOP);
                            text_fade_nx = 2'd0;
                            text_on_nx   = 1'b1;
                            fade_cnt_nx  = '0;
                            state_nx     = FADE_IN;
                        end else begin
                            dark_cnt_nx  = dark_cnt + DARK_W'(1);
                        end
                    end
                    FADE_IN: begin
                        if (fade_cnt == FADE_W'(FADE_STEP_FRAMES - 1)) begin
                            text_fade_nx = text_fade + 2'd1;
                            fade_cnt_nx  = '0;
                            if (text_fade == 2'd2) begin
                                state_nx    = HOLD;
                                hold_cnt_nx = '0;
                            end
                        end else begin
                            fade_cnt_nx  = fade_cnt + FADE_W'(1);
                        end
                    end
                    default: state_nx = HOLD;
                endcase
            end
        end
    end

    assign bus.frame_tick  = frame_tick;
    assign bus.frame_cnt   = frame_cnt;
    assign bus.ring_phase  = ring_phase;
    assign bus.text_y      = text_y;
    assign bus.text_on     = text_on;
    assign bus.text_fade   = text_fade;
    assign bus.scene_state = state;
endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Directed bench for demo_scene_sequencer: reset, tick detection, ring phase, full scene cycle, pause.
module tb_demo_scene_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    demo_scene_if bus ();

    demo_scene_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame: two cycles of sync low, two high; the tick lands on the first high cycle.
    task automatic frame();
        bus.vsync = 1'b0;
        step();
        step();
        bus.vsync = 1'b1;
        step();
        step();
    endtask

    logic       saw_tick;
    logic [9:0] prev_y;
    logic [9:0] held_y;
    logic [7:0] held_ring;
    int         fall_ticks;

    initial begin
        reset     = 1'b1;
        bus.vsync = 1'b1;
        bus.pause = 1'b0;
        bus.speed = 2'd0;
        step();
        step();
        reset = 1'b0;
        step();

        // Reset state before any frame
        check("rst_frame_cnt", 32'(bus.frame_cnt), 0);
        check("rst_text_y", 32'(bus.text_y), 20);
        check("rst_text_fade", 32'(bus.text_fade), 3);
        check("rst_state", 32'(bus.scene_state), 0);
        check("rst_text_on", 32'(bus.text_on), 1);
        check("rst_frame_tick", 32'(bus.frame_tick), 0);

        // One vsync pulse: outputs update one cycle after the rise
        bus.vsync = 1'b0;
        step();
        step();
        check("no_tick_in_sync", 32'(bus.frame_tick), 0);
        bus.vsync = 1'b1;
        step();
        check("tick_pulse", 32'(bus.frame_tick), 1);
        check("tick_frame_cnt", 32'(bus.frame_cnt), 1);
        check("tick_ring", 32'(bus.ring_phase), 1);
        step();
        check("tick_one_cycle", 32'(bus.frame_tick), 0);
        check("hold_between_ticks", 32'(bus.frame_cnt), 1);

        // vsync rises while reset is held; no tick after release
        #2 reset = 1'b1;
        bus.vsync = 1'b0;
        step();
        step();
        bus.vsync = 1'b1;
        step();
        step();
        reset = 1'b0;
        saw_tick = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            saw_tick = saw_tick | bus.frame_tick;
        end
        check("no_tick_after_reset", 32'(saw_tick), 0);
        check("no_count_after_reset", 32'(bus.frame_cnt), 0);

        // speed=3 for 40 frames: 320 mod 256
        bus.speed = 2'd3;
        for (int i = 0; i < 40; i++) frame();
        check("ring_speed3", 32'(bus.ring_phase), 64);
        check("frame_cnt_40", 32'(bus.frame_cnt), 40);
        check("still_hold_40", 32'(bus.scene_state), 0);

        // HOLD lasts 256 ticks
        bus.speed = 2'd0;
        for (int i = 0; i < 215; i++) frame();
        check("hold_at_255", 32'(bus.scene_state), 0);
        frame();
        check("fall_at_256", 32'(bus.scene_state), 1);
        check("fall_entry_y", 32'(bus.text_y), 20);
        check("ring_at_256", 32'(bus.ring_phase), 24);
        frame();
        check("first_fall_y", 32'(bus.text_y), 21);
        for (int i = 0; i < 19; i++) frame();
        check("fall20_y", 32'(bus.text_y), 44);
        check("fall20_ring", 32'(bus.ring_phase), 44);

        // Pause 10 frames mid-FALL
        held_y    = bus.text_y;
        held_ring = bus.ring_phase;
        bus.pause = 1'b1;
        for (int i = 0; i < 10; i++) frame();
        check("pause_frame_cnt", 32'(bus.frame_cnt), 286);
        check("pause_text_y", 32'(bus.text_y), 32'(held_y));
        check("pause_ring", 32'(bus.ring_phase), 32'(held_ring));
        check("pause_state", 32'(bus.scene_state), 1);
        bus.pause = 1'b0;

        // Resume: velocity 2 preserved, then fall to the swallow row
        fall_ticks = 0;
        prev_y = bus.text_y;
        while (bus.scene_state == 2'd1 && fall_ticks < 120) begin
            frame();
            fall_ticks++;
            if (fall_ticks == 1) check("resume_vel", 32'(bus.text_y), 46);
            check("fall_step_le8", 32'(bus.text_y - prev_y <= 10'd8), 1);
            prev_y = bus.text_y;
        end
        check("fall_reach_dark", 32'(bus.scene_state), 2);
        check("fall_tick_count", 32'(fall_ticks), 63);
        check("swallow_y", 32'(bus.text_y), 276);
        check("swallow_off", 32'(bus.text_on), 0);
        check("swallow_ring", 32'(bus.ring_phase), 107);

        // DARK 32 ticks at speed 1
        bus.speed = 2'd1;
        for (int i = 0; i < 31; i++) frame();
        check("dark_31", 32'(bus.scene_state), 2);
        check("dark_31_off", 32'(bus.text_on), 0);
        frame();
        check("respawn_state", 32'(bus.scene_state), 3);
        check("respawn_y", 32'(bus.text_y), 20);
        check("respawn_fade", 32'(bus.text_fade), 0);
        check("respawn_on", 32'(bus.text_on), 1);
        check("respawn_ring", 32'(bus.ring_phase), 171);

        // FADE_IN 24 ticks at speed 2
        bus.speed = 2'd2;
        for (int i = 0; i < 8; i++) frame();
        check("fade_8", 32'(bus.text_fade), 1);
        for (int i = 0; i < 15; i++) frame();
        check("fade_23", 32'(bus.text_fade), 2);
        check("fade_23_state", 32'(bus.scene_state), 3);
        frame();
        check("fade_done", 32'(bus.text_fade), 3);
        check("fade_done_state", 32'(bus.scene_state), 0);
        check("final_ring", 32'(bus.ring_phase), 11);
        check("final_frame_cnt", 32'(bus.frame_cnt), 405);

        // Reset asserted mid-frame takes effect before the next edge
        bus.vsync = 1'b0;
        step();
        #2 reset = 1'b1;
        #1;
        check("mid_rst_frame_cnt", 32'(bus.frame_cnt), 0);
        check("mid_rst_ring", 32'(bus.ring_phase), 0);
        check("mid_rst_text_y", 32'(bus.text_y), 20);
        check("mid_rst_text_on", 32'(bus.text_on), 1);
        check("mid_rst_fade", 32'(bus.text_fade), 3);
        check("mid_rst_state", 32'(bus.scene_state), 0);
        check("mid_rst_tick", 32'(bus.frame_tick), 0);
        step();
        reset = 1'b0;
        bus.speed = 2'd0;
        frame();
        check("post_rst_frame_cnt", 32'(bus.frame_cnt), 1);
        check("post_rst_ring", 32'(bus.ring_phase), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
